// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, the canonical NOP and fetch FSM states.
// Fetch misalignment trapping is selected by FETCH_MISALIGN_TRAP_EN.
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC target mux with alignment handling.
// FETCH_MISALIGN_TRAP_EN keeps bit 1 so the caller can trap on it.
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            pcsrc,
    input  logic            jalr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] pctarget,
    input  logic [XLEN-1:0] aluresult,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw = pc_plus4;
        unique case (1'b1)
            jalr:           raw = aluresult & ~XLEN'(1);
            (pcsrc & ~jalr): raw = pctarget;
            default:        raw = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc = raw;
`else
    assign next_pc = raw & ~XLEN'(3);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-outstanding imem request, hold.
// Define FETCH_MISALIGN_TRAP_EN to halt on a misaligned next PC.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            PCSrc,
    input  logic            Jalr,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misaligned,
`endif
    output logic [31:0]     retired
);

    localparam logic [1:0] FETCH = FS_FETCH;
    localparam logic [1:0] WAIT  = FS_WAIT;
    localparam logic [1:0] HOLD  = FS_HOLD;
    localparam logic [1:0] HALT  = FS_HALT;

    logic [1:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [31:0]     retired_q;
    logic [XLEN-1:0] next_pc;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pcsrc     (PCSrc),
        .jalr      (Jalr),
        .pc_plus4  (pc_plus4),
        .pctarget  (PCTarget),
        .aluresult (ALUResult),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            retired_q <= '0;
        end else begin
            unique case (1'b1)
                (state == FETCH): state <= WAIT;
                (state == WAIT): begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        state   <= HOLD;
                    end
                end
                (state == HOLD): begin
                    if (instr_ready) begin
                        pc_q      <= next_pc;
                        retired_q <= retired_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
                        state     <= next_pc[1] ? HALT : FETCH;
`else
                        state     <= FETCH;
`endif
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // rst_n gating keeps the strobe quiet while memory is also in reset
    assign imem_req    = rst_n & (state == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state == HOLD);
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign retired     = retired_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned  = (state == HALT);
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the PC register and issues one-outstanding word requests to instruction memory.
- Holds the returned instruction and presents it, with its op/funct3/funct7b5 fields, to the controller.
- Computes the next PC from the controller's PCSrc/Jalr when the instruction is accepted.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  request strobe, one cycle per fetch.
- imem_addr  output  XLEN  word address (byte address, [1:0]=00).
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  held instruction valid.
- instr_ready  input  1  execute stage accepts the instruction this cycle.
- instr  output  32  held instruction.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7b5  output  1  instr[30].
- pc  output  XLEN  PC of held instruction.
- pc_plus4  output  XLEN  pc+4.
- PCSrc  input  1  branch-taken/jump from controller.
- Jalr  input  1  jalr select from controller.
- PCTarget  input  XLEN  pc+imm from datapath.
- ALUResult  input  XLEN  rs1+imm from datapath (jalr target).
- retired  output  32  count of accepted instructions.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (nop), retired=0, imem_req=0, instr_valid=0.
- imem_req is gated low while rst_n=0.
- State FETCH:
  - imem_req=1, imem_addr=pc for exactly one cycle, then -> WAIT.
  - First request is in the first cycle after rst_n deasserts.
- State WAIT:
  - imem_req=0; stay until imem_rvalid=1.
  - On rvalid, capture imem_rdata into instr -> HOLD.
  - Memory latency is unbounded; zero-wait memory gives rvalid in the cycle after req.
- State HOLD:
  - instr_valid=1; instr, op, funct3, funct7b5 and pc are stable until accept.
  - On instr_valid & instr_ready (accept), pc <= next_pc, retired <= retired+1 (wraps 2^32-1 -> 0), then -> FETCH.
- next_pc, evaluated in the accept cycle:
  - Jalr=1 -> {ALUResult[XLEN-1:1],1'b0}.
  - else PCSrc=1 -> PCTarget.
  - else pc_plus4.
  - Jalr has priority over PCSrc when both are 1.
- Throughput: at best one instruction per 3 cycles (FETCH, WAIT, HOLD). No speculation, hence no flush.
- imem_rvalid outside WAIT is ignored.
- PCSrc/Jalr/targets outside an accept cycle are ignored.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Reset mid-WAIT: the request is abandoned. Instruction memory shares rst_n and drops pending responses.
- instr_ready held high while not in HOLD has no effect.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN
- Defined:
  - If the accepted next_pc has bit[1]=1, the unit enters a terminal state HALT.
  - In HALT: output misaligned=1 (extra 1-bit port, reset 0), imem_req=0, instr_valid=0, pc=offending address.
  - Only reset exits HALT.
- Undefined:
  - No misaligned port; next_pc[1:0] is forced to 00 before loading.

Decomposition:
- Shared package riscv_pkg: opcode constants, NOP_INSTR=32'h0000_0013, fetch state enum {FETCH, WAIT, HOLD, HALT}, XLEN default.
- Sub-module next_pc_sel: combinational target mux and alignment. It is the single natural split and is reusable by a later pipelined fetch.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory -> cycle 1 imem_req=1, addr=0; cycle 2 rvalid with 32'h00500093; cycle 3 instr_valid=1, op=7'h13, funct3=0, pc=0.
- Accept with PCSrc=0, Jalr=0 at pc=0 -> next request addr=4, retired=1.
- Accept with PCSrc=1, PCTarget=32'h40 -> next addr=32'h40.
- Accept with PCSrc=1, Jalr=1, ALUResult=32'h101, PCTarget=32'h80 -> next addr=32'h100.
- Memory latency 5 cycles, instr_ready low for 4 cycles in HOLD -> single imem_req pulse, instr stable throughout, no extra retire.
- rst_n asserted mid-WAIT -> outputs return to reset values immediately, without waiting for a clock edge; first request after release is addr=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN: Jalr target 32'h102 -> misaligned=1, imem_req stays 0.
